// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle fetch/read/exec/write/sleep control FSM producing timed commit strobes.
module instruction_sequencer #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          opcode,
  input  logic                skip,
  input  logic                mem_ready,
  input  logic                irq,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_load,
  output logic                opnd_load,
  output logic                w_load,
  output logic                pc_inc,
  output logic [1:0]          pc_step,
  output logic                pc_jump,
  output logic                pc_save,
  output logic                pc_vector,
  output logic                irq_ack,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_SLEEP  = 3'd5
  } state_t;
  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [3:0]          cls;
  logic                d, rmw_cls, needs_read, needs_write, w_commit, commit;
  assign cls         = opcode[4:1];
  assign d           = opcode[0];
  assign rmw_cls     = cls >= 4'h3 && cls <= 4'h9;
  assign needs_read  = (cls == 4'h0 && !d) || (cls >= 4'h3 && cls <= 4'hB);
  assign needs_write = cls == 4'h1 || (d && (cls == 4'h0 || rmw_cls));
  assign w_commit    = cls == 4'h2 || (!d && (cls == 4'h0 || rmw_cls));
  // Strobes are held off while reset is high so an in-flight request drops immediately.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    opnd_load = 1'b0;
    irq_ack   = 1'b0;
    pc_vector = 1'b0;
    commit    = 1'b0;
    if (!reset)
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: state_d = needs_read ? S_READ : S_EXEC;
        S_READ: begin
          mem_req   = 1'b1;
          addr_sel  = 1'b1;
          opnd_load = mem_ready;
          state_d   = mem_ready ? S_EXEC : S_READ;
        end
        S_EXEC: begin
          commit  = !needs_write;
          state_d = needs_write ? S_WRITE : cls == 4'hE ? S_SLEEP : S_FETCH;
        end
        S_WRITE: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          commit   = mem_ready;
          state_d  = mem_ready ? S_FETCH : S_WRITE;
        end
        S_SLEEP: begin
          irq_ack   = irq;
          pc_vector = irq;
          state_d   = irq ? S_FETCH : S_SLEEP;
        end
        default: state_d = S_FETCH;
      endcase
    pc_jump   = commit && (cls == 4'hC || cls == 4'hD || cls == 4'hF);
    pc_save   = commit && cls == 4'hE;
    w_load    = commit && w_commit;
    pc_inc    = commit && !pc_jump;
    pc_step   = !pc_inc ? 2'd0 : (state_q == S_EXEC && skip && cls[3:1] == 3'b101) ? 2'd2 : 2'd1;
    retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, commit};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  assign state   = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: table vectors, directed corner sequences and random instructions against a phase-level model.
module tb_instruction_sequencer;
  localparam int RW = 4;
  logic          clk = 1'b0;
  logic          reset, skip, mem_ready, irq;
  logic [4:0]    opcode;
  logic          mem_req, mem_we, addr_sel, ir_load, opnd_load, w_load, pc_inc;
  logic [1:0]    pc_step;
  logic          pc_jump, pc_save, pc_vector, irq_ack;
  logic [2:0]    state;
  logic [RW-1:0] retired;
  logic [15:0]   obs, last_obs;
  logic [RW-1:0] ret_m;
  int            checks = 0, errors = 0;

  instruction_sequencer #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .skip(skip), .mem_ready(mem_ready), .irq(irq),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load), .opnd_load(opnd_load),
    .w_load(w_load), .pc_inc(pc_inc), .pc_step(pc_step), .pc_jump(pc_jump), .pc_save(pc_save),
    .pc_vector(pc_vector), .irq_ack(irq_ack), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;
  assign obs = {state, mem_req, mem_we, addr_sel, ir_load, opnd_load, w_load, pc_inc, pc_step,
                pc_jump, pc_save, pc_vector, irq_ack};

  // Class membership masks, bit n = class n.
  localparam logic [15:0] RD_CLS   = 16'h0FF8;
  localparam logic [15:0] WD_CLS   = 16'h03F9;
  localparam logic [15:0] WC_CLS   = 16'h03F9;
  localparam logic [15:0] JMP_CLS  = 16'hB000;
  localparam logic [15:0] SKIP_CLS = 16'h0C00;

  typedef struct {
    logic [4:0] op;
    bit         sk;
    int         wf, wr, ww, slp;
    logic       wl, inc;
    logic [1:0] stp;
    logic       jmp, sav;
  } vec_t;

  function automatic logic [15:0] mk(input logic [2:0] st, input bit req, we, as, irl, opl, wl, inc,
                                     input logic [1:0] stp, input bit jmp, sav, vec, ack);
    return {st, req, we, as, irl, opl, wl, inc, stp, jmp, sav, vec, ack};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic [15:0] exp);
    #1;
    last_obs = obs;
    chk({nm, " outputs"}, obs, exp);
    chk({nm, " retired"}, retired, ret_m);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [4:0] op, input bit sk, input int wf, input int wr_w,
                           input int ww, input int slp, input bit noise, output logic [15:0] cobs);
    logic [3:0] c;
    bit d, rd, wr, wc, jmp, sav;
    logic [1:0] stp;
    c   = op[4:1];
    d   = op[0];
    rd  = (c == 0 && !d) || RD_CLS[c];
    wr  = c == 1 || (d && WD_CLS[c]);
    wc  = c == 2 || (!d && WC_CLS[c]);
    jmp = JMP_CLS[c];
    sav = c == 14;
    stp = jmp ? 2'd0 : (SKIP_CLS[c] && sk) ? 2'd2 : 2'd1;
    for (int k = 0; k <= wf; k++) begin
      opcode = (k == wf) ? op : 5'($urandom);
      mem_ready = (k == wf);
      irq = noise ? 1'($urandom) : 1'b0;
      skip = 1'($urandom);
      step("fetch", mk(0, 1, 0, 0, k == wf, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    opcode = op;
    mem_ready = 1'($urandom);
    irq = noise ? 1'($urandom) : 1'b0;
    step("decode", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (rd)
      for (int k = 0; k <= wr_w; k++) begin
        mem_ready = (k == wr_w);
        irq = noise ? 1'($urandom) : 1'b0;
        step("read", mk(2, 1, 0, 1, 0, k == wr_w, 0, 0, 0, 0, 0, 0, 0));
      end
    mem_ready = 1'($urandom);
    skip = sk;
    irq = noise ? 1'($urandom) : 1'b0;
    if (wr) step("exec", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    else begin
      step("exec commit", mk(3, 0, 0, 0, 0, 0, wc, !jmp, stp, jmp, sav, 0, 0));
      cobs = last_obs;
      ret_m++;
    end
    if (wr)
      for (int k = 0; k <= ww; k++) begin
        mem_ready = (k == ww);
        skip = 1'($urandom);
        irq = noise ? 1'($urandom) : 1'b0;
        if (k < ww) step("write", mk(4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        else begin
          step("write commit", mk(4, 1, 1, 1, 0, 0, wc, !jmp, stp, jmp, sav, 0, 0));
          cobs = last_obs;
          ret_m++;
        end
      end
    if (sav) begin
      for (int k = 0; k < slp; k++) begin
        irq = 1'b0;
        mem_ready = 1'($urandom);
        step("sleep", mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      irq = 1'b1;
      step("wake", mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    end
    irq = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [15:0] cobs;
    int n, waitcnt, we_bad;
    bit w_seen, done, got;
    tbl = '{
      '{5'h04, 0, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0},
      '{5'h07, 0, 1, 1, 1, 0, 0, 1, 2'd1, 0, 0},
      '{5'h14, 1, 0, 0, 0, 0, 0, 1, 2'd2, 0, 0},
      '{5'h14, 0, 0, 1, 0, 0, 0, 1, 2'd1, 0, 0},
      '{5'h17, 1, 0, 0, 0, 0, 0, 1, 2'd2, 0, 0},
      '{5'h18, 1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0},
      '{5'h1B, 0, 2, 0, 0, 0, 0, 0, 2'd0, 1, 0},
      '{5'h1E, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0},
      '{5'h00, 0, 0, 2, 0, 0, 1, 1, 2'd1, 0, 0},
      '{5'h01, 0, 0, 0, 2, 0, 0, 1, 2'd1, 0, 0},
      '{5'h03, 1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 0},
      '{5'h05, 0, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0},
      '{5'h12, 1, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0},
      '{5'h13, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 0},
      '{5'h1C, 0, 0, 0, 0, 10, 0, 1, 2'd1, 0, 1}
    };
    reset = 1'b1; opcode = '0; skip = 1'b0; mem_ready = 1'b0; irq = 1'b0; ret_m = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", obs, 16'h0);
    chk("reset retired", retired, 0);
    reset = 1'b0;
    #1;
    chk("post-reset fetch", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      cobs = 'x;
      run_instr(tbl[i].op, tbl[i].sk, tbl[i].wf, tbl[i].wr, tbl[i].ww, tbl[i].slp, 1'b0, cobs);
      chk($sformatf("table %0d commit", i), cobs[7:2],
          {tbl[i].wl, tbl[i].inc, tbl[i].stp, tbl[i].jmp, tbl[i].sav});
    end
    // rlm with every phase held off for two wait cycles
    opcode = 5'h07; irq = 1'b0; n = 0; waitcnt = 0; we_bad = 0; w_seen = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      mem_ready = mem_req && waitcnt == 2;
      waitcnt = (mem_req && !mem_ready) ? waitcnt + 1 : 0;
      #1;
      n++;
      if (w_load) w_seen = 1;
      if (mem_we != (state == 3'd4)) we_bad++;
      if (pc_inc) done = 1;
      @(negedge clk);
    end
    ret_m++;
    chk("rlm committed", done, 1);
    chk("rlm cycles", n, 11);
    chk("rlm w_load", w_seen, 0);
    chk("rlm mem_we only in write", we_bad, 0);
    chk("rlm retired", retired, ret_m);
    // asynchronous reset during a pending write
    opcode = 5'h01; mem_ready = 1'b1; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (state == 3'd4) got = 1;
      else @(negedge clk);
    end
    mem_ready = 1'b0;
    chk("reached write", got, 1);
    #1;
    chk("write mem_req", {mem_req, mem_we}, 2'b11);
    reset = 1'b1;
    #1;
    ret_m = '0;
    chk("async reset outputs", obs, 16'h0);
    chk("async reset retired", retired, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release fetch", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 150; i++)
      run_instr(5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, cobs);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
